// File: rtl/order_dispatcher_if.sv
`default_nettype none
// =============================================================================
// order_dispatcher_if : valid/ready order port between dispatcher and exchange.
// Revision 1.0
// =============================================================================
interface order_dispatcher_if #(
  parameter int PRICE_W = 8,
  parameter int QTY_W   = 8
);
  logic               order_valid;
  logic               order_ready;
  logic               order_side;
  logic [PRICE_W-1:0] order_price;
  logic [QTY_W-1:0]   order_qty;
  logic [7:0]         order_id;

  modport master (
    output order_valid, order_side, order_price, order_qty, order_id,
    input  order_ready
  );

  modport slave (
    input  order_valid, order_side, order_price, order_qty, order_id,
    output order_ready
  );
endinterface
`default_nettype wire

// File: rtl/order_dispatcher.sv
`default_nettype none
// =============================================================================
// order_dispatcher : trigger rising edge -> one marketable order, then cooldown.
// ORDER_DISPATCHER_ONESHOT_EN: return to IDLE after each order.  Revision 1.0
// =============================================================================
module order_dispatcher #(
  parameter int PRICE_W         = 8,
  parameter int QTY_W           = 8,
  parameter int COOLDOWN_CYCLES = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               arm_write_enable,
  input  logic               arm_side,
  input  logic [QTY_W-1:0]   arm_qty,
  input  logic               trigger_satisfied,
  input  logic [PRICE_W-1:0] bid_price,
  input  logic [PRICE_W-1:0] ask_price,
  output logic               armed,
  output logic [7:0]         orders_sent,
  order_dispatcher_if.master bus
);

  localparam int CNT_W = (COOLDOWN_CYCLES > 0) ? $clog2(COOLDOWN_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(COOLDOWN_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ARMED    = 2'd1,
    SEND     = 2'd2,
    COOLDOWN = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic               trig_q;
  logic               tmpl_side_q, tmpl_side_d;
  logic [QTY_W-1:0]   tmpl_qty_q, tmpl_qty_d;
  logic               side_q, side_d;
  logic [PRICE_W-1:0] price_q, price_d;
  logic [QTY_W-1:0]   qty_q, qty_d;
  logic [7:0]         id_q, id_d;
  logic [7:0]         sent_q, sent_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               valid_q, valid_d;
  logic               armed_q, armed_d;
  logic               fire, arm_zero;
  state_t             rearm_state;

  always_comb begin
    fire        = trigger_satisfied & ~trig_q;
    arm_zero    = arm_write_enable && (arm_qty == '0);
    state_d     = state_q;
    tmpl_side_d = tmpl_side_q;
    tmpl_qty_d  = tmpl_qty_q;
    side_d      = side_q;
    price_d     = price_q;
    qty_d       = qty_q;
    id_d        = id_q;
    sent_d      = sent_q;
    cnt_d       = cnt_q;

    // Template loads everywhere except SEND; a fire in the same cycle reads the old _q copy.
    if (arm_write_enable && (state_q != SEND)) begin
      tmpl_side_d = arm_side;
      tmpl_qty_d  = arm_qty;
    end

`ifdef ORDER_DISPATCHER_ONESHOT_EN
    rearm_state = IDLE;
`else
    // A disarm that coincided with the last fire leaves a zero template: stay disarmed.
    rearm_state = (tmpl_qty_d != '0) ? ARMED : IDLE;
`endif

    case (state_q)
      IDLE: begin
        if (arm_write_enable && !arm_zero) state_d = ARMED;
      end
      ARMED: begin
        if (fire) begin
          side_d  = tmpl_side_q;
          qty_d   = tmpl_qty_q;
          price_d = tmpl_side_q ? bid_price : ask_price;
          state_d = SEND;
        end else if (arm_zero) begin
          state_d = IDLE;
        end
      end
      SEND: begin
        if (bus.order_ready) begin
          id_d   = id_q + 8'd1;
          sent_d = (sent_q == 8'hFF) ? sent_q : sent_q + 8'd1;
          if (COOLDOWN_CYCLES == 0) begin
            state_d = rearm_state;
          end else begin
            state_d = COOLDOWN;
            cnt_d   = CNT_LOAD;
          end
        end
      end
      COOLDOWN: begin
        if (arm_zero)                state_d = IDLE;
        else if (cnt_q <= CNT_ONE)   state_d = rearm_state;
        else                         cnt_d   = cnt_q - CNT_ONE;
      end
      default: state_d = IDLE;
    endcase

    valid_d = (state_d == SEND);
    armed_d = (state_d == ARMED);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      trig_q      <= 1'b0;
      tmpl_side_q <= 1'b0;
      tmpl_qty_q  <= '0;
      side_q      <= 1'b0;
      price_q     <= '0;
      qty_q       <= '0;
      id_q        <= 8'd0;
      sent_q      <= 8'd0;
      cnt_q       <= '0;
      valid_q     <= 1'b0;
      armed_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      trig_q      <= trigger_satisfied;
      tmpl_side_q <= tmpl_side_d;
      tmpl_qty_q  <= tmpl_qty_d;
      side_q      <= side_d;
      price_q     <= price_d;
      qty_q       <= qty_d;
      id_q        <= id_d;
      sent_q      <= sent_d;
      cnt_q       <= cnt_d;
      valid_q     <= valid_d;
      armed_q     <= armed_d;
    end
  end

  assign bus.order_valid = valid_q;
  assign bus.order_side  = side_q;
  assign bus.order_price = price_q;
  assign bus.order_qty   = qty_q;
  assign bus.order_id    = id_q;
  assign armed           = armed_q;
  assign orders_sent     = sent_q;

endmodule
`default_nettype wire

// File: tb/tb_order_dispatcher.sv
`default_nettype none
// tb_order_dispatcher : directed + random stimulus, reference model feeds a scoreboard
// queue that a negedge monitor drains on each offered/accepted order.
module tb_order_dispatcher;
  localparam int C = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       arm_write_enable = 1'b0;
  logic       arm_side = 1'b0;
  logic [7:0] arm_qty = 8'd0;
  logic       trigger_satisfied = 1'b0;
  logic [7:0] bid_price = 8'd0;
  logic [7:0] ask_price = 8'd0;
  logic       armed;
  logic [7:0] orders_sent;

  always #5 clock = ~clock;

  order_dispatcher_if #(.PRICE_W(8), .QTY_W(8)) bus ();

  order_dispatcher #(.PRICE_W(8), .QTY_W(8), .COOLDOWN_CYCLES(C)) dut (
    .clock             (clock),
    .reset             (reset),
    .arm_write_enable  (arm_write_enable),
    .arm_side          (arm_side),
    .arm_qty           (arm_qty),
    .trigger_satisfied (trigger_satisfied),
    .bid_price         (bid_price),
    .ask_price         (ask_price),
    .armed             (armed),
    .orders_sent       (orders_sent),
    .bus               (bus)
  );

  typedef struct packed {
    logic       side;
    logic [7:0] price;
    logic [7:0] qty;
    logic [7:0] id;
  } ord_t;

  ord_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  bit   mon_en = 1'b0;

  // Reference model: "enabled" template, one outstanding order, and the first
  // cycle index at which a new fire may be honoured again.
  bit         m_en, m_pend, m_prev, m_side;
  logic [7:0] m_qty;
  int         m_open, m_lock, m_k, m_hs;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_en = 0; m_pend = 0; m_prev = 0; m_side = 0; m_qty = 0;
    m_open = 0; m_lock = 0; m_k = 0; m_hs = 0;
  endtask

  task automatic step(input bit we, input bit s, input logic [7:0] q, input bit trig,
                      input logic [7:0] bid, input logic [7:0] ask, input bit rdy);
    bit fire;
    arm_write_enable  = we;
    arm_side          = s;
    arm_qty           = q;
    trigger_satisfied = trig;
    bid_price         = bid;
    ask_price         = ask;
    bus.order_ready   = rdy;
    @(posedge clock);
    m_k++;
    fire   = trig && !m_prev;
    m_prev = trig;
    if (m_pend) begin
      if (rdy) begin
        m_pend = 0;
        m_hs++;
        m_open = m_k + C + 1;
`ifdef ORDER_DISPATCHER_ONESHOT_EN
        m_en   = 0;
        m_lock = m_open;
`endif
      end
    end else begin
      if (m_en && m_k >= m_open && fire) begin
        exp_q.push_back('{side: m_side, price: (m_side ? bid : ask), qty: m_qty, id: m_hs[7:0]});
        m_pend = 1;
      end
      if (we) begin
        m_side = s;
        m_qty  = q;
        if (q == 0) begin
          m_en = 0; m_open = 0;
        end else if (m_k >= m_lock) begin
          m_en = 1;
        end
      end
    end
    #1;
    chk("armed", 32'(armed), 32'(m_en && !m_pend && (m_k + 1 >= m_open)));
    chk("orders_sent", 32'(orders_sent), 32'((m_hs > 255) ? 255 : m_hs));
  endtask

  task automatic idle(input int n, input bit trig, input bit rdy);
    for (int i = 0; i < n; i++) step(0, 0, 8'd0, trig, 8'h11, 8'h22, rdy);
  endtask

  // Monitor: every cycle an order is offered it must match the queue head.
  initial begin
    forever begin
      @(negedge clock);
      if (mon_en && bus.order_valid) begin
        if (exp_q.size() == 0) begin
          chk("spurious_order_valid", 32'(bus.order_valid), 32'd0);
        end else begin
          chk("order_side",  32'(bus.order_side),  32'(exp_q[0].side));
          chk("order_price", 32'(bus.order_price), 32'(exp_q[0].price));
          chk("order_qty",   32'(bus.order_qty),   32'(exp_q[0].qty));
          chk("order_id",    32'(bus.order_id),    32'(exp_q[0].id));
          if (bus.order_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    bit tg;
    bus.order_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    chk("rst_valid", 32'(bus.order_valid), 32'd0);
    chk("rst_price", 32'(bus.order_price), 32'd0);
    chk("rst_qty",   32'(bus.order_qty),   32'd0);
    chk("rst_id",    32'(bus.order_id),    32'd0);
    chk("rst_armed", 32'(armed),           32'd0);
    chk("rst_sent",  32'(orders_sent),     32'd0);
    reset  = 1'b1;
    mon_en = 1'b1;

    // Buy qty 10 at ask 0x64, ready already high.
    step(1, 0, 8'd10, 0, 8'h50, 8'h64, 1);
    step(0, 0, 8'd0, 1, 8'h50, 8'h64, 1);
    step(0, 0, 8'd0, 0, 8'h50, 8'h64, 1);
    idle(6, 0, 0);

    // Sell qty 5 at bid 0x50; book moves while ready is held low.
    step(1, 1, 8'd5, 0, 8'h50, 8'h90, 0);
    step(0, 0, 8'd0, 1, 8'h50, 8'h90, 0);
    for (int i = 0; i < 6; i++) step(0, 0, 8'd0, 0, 8'h40, 8'h90, 0);
    step(0, 0, 8'd0, 0, 8'h40, 8'h90, 1);

    // Re-pulse 2 cycles after handshake is dropped; 6 cycles after is taken.
    step(0, 0, 8'd0, 0, 8'h40, 8'h90, 0);
    step(0, 0, 8'd0, 1, 8'h40, 8'h90, 0);
    step(0, 0, 8'd0, 0, 8'h40, 8'h90, 0);
    idle(2, 0, 0);
    step(0, 0, 8'd0, 1, 8'h41, 8'h90, 0);
    step(0, 0, 8'd0, 0, 8'h41, 8'h90, 1);

    // Trigger held high across re-arm, then a fresh edge.
    idle(8, 1, 1);
    step(0, 0, 8'd0, 0, 8'h42, 8'h91, 1);
    step(0, 0, 8'd0, 1, 8'h43, 8'h92, 1);
    step(0, 0, 8'd0, 0, 8'h43, 8'h92, 1);

    // Disarm during cooldown, then triggers must be ignored.
    idle(1, 0, 0);
    step(1, 0, 8'd0, 0, 8'h43, 8'h92, 0);
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 8'd0, 1, 8'h44, 8'h93, 1);
      step(0, 0, 8'd0, 0, 8'h44, 8'h93, 1);
    end

    // Random traffic.
    tg = 0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 2) == 0) tg = ~tg;
      step(($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 255)),
           tg, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
           1'($urandom_range(0, 1)));
    end

    // Burst past 256 orders for id wrap and counter saturation.
    step(1, 1, 8'd3, 0, 8'h10, 8'h20, 1);
    for (int i = 0; i < 4000 && m_hs < 300; i++)
      step(0, 0, 8'd0, 1'(i % 2), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1);
    idle(10, 0, 1);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    chk("final_sent", 32'(orders_sent), 32'd255);

    // Asynchronous reset while an order is being offered.
    idle(6, 0, 0);
    step(1, 1, 8'd9, 0, 8'h33, 8'h44, 0);
    step(0, 0, 8'd0, 1, 8'h33, 8'h44, 0);
    chk("send_valid_before_reset", 32'(bus.order_valid), 32'd1);
    #2;
    mon_en = 1'b0;
    reset  = 1'b0;
    #1;
    chk("arst_valid", 32'(bus.order_valid), 32'd0);
    chk("arst_side",  32'(bus.order_side),  32'd0);
    chk("arst_price", 32'(bus.order_price), 32'd0);
    chk("arst_qty",   32'(bus.order_qty),   32'd0);
    chk("arst_id",    32'(bus.order_id),    32'd0);
    chk("arst_armed", 32'(armed),           32'd0);
    chk("arst_sent",  32'(orders_sent),     32'd0);
    exp_q.delete();
    model_reset();
    trigger_satisfied = 1'b0;
    @(posedge clock);
    #1;
    reset  = 1'b1;
    mon_en = 1'b1;
    idle(4, 0, 1);
    chk("post_reset_valid", 32'(bus.order_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/order_dispatcher.md
# order_dispatcher

Downstream stage of the trigger comparator: converts a rising edge of `trigger_satisfied` into a single marketable order on a valid/ready port toward the exchange interface. Holds an order template (side, quantity), prices the order from the current top of book, and holds fields stable until accepted. After each accepted order it enforces a cooldown before it can fire again.

## Interface
- `PRICE_W`, 8, price width; matches `bid_price`/`ask_price`/`trigger_price`.
- `QTY_W`, 8, order quantity width.
- `COOLDOWN_CYCLES`, 4, cycles spent in COOLDOWN after each accepted order; 0 is legal.

Ports. One clock; reset is asynchronous and active-low.
- `clock`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low reset.
- `arm_write_enable`  in  1  load template from `arm_side`/`arm_qty`.
- `arm_side`  in  1  0 = buy, 1 = sell.
- `arm_qty`  in  QTY_W  order quantity; 0 means disarm.
- `trigger_satisfied`  in  1  from the trigger stage.
- `bid_price`  in  PRICE_W  best bid.
- `ask_price`  in  PRICE_W  best ask.
- `order_valid`  out  1  order offered.
- `order_ready`  in  1  downstream accepts.
- `order_side`  out  1  side of offered order.
- `order_price`  out  PRICE_W  price of offered order.
- `order_qty`  out  QTY_W  quantity of offered order.
- `order_id`  out  8  sequence number of offered order.
- `armed`  out  1  high in ARMED state.
- `orders_sent`  out  8  accepted-order count, saturating at 255.

## Operation
- FSM states: IDLE, ARMED, SEND, COOLDOWN. Reset state IDLE.
- Edge detect: register `trig_q` samples `trigger_satisfied` every cycle, resets to 0; fire = `trigger_satisfied & ~trig_q`.
- IDLE: `arm_write_enable` with `arm_qty != 0` loads template and moves to ARMED. With `arm_qty == 0`, stays IDLE.
- ARMED: on fire, capture side, qty, and price into output registers. Buy captures `ask_price`; sell captures `bid_price`. Move to SEND. Arm write with `arm_qty == 0` moves to IDLE. Nonzero arm write updates the template. If fire and arm write coincide, fire wins and uses the old template; the arm write is then applied.
- SEND: `order_valid` = 1; all `order_*` fields stay frozen until handshake (`order_valid & order_ready`). Arm writes are ignored. On handshake:
  - `order_id` increments, wrapping 255 -> 0.
  - `orders_sent` increments, saturating at 255.
  - Go to COOLDOWN loaded with `COOLDOWN_CYCLES`; if that is 0, go directly to ARMED.
- COOLDOWN: counter decrements each cycle; at 1 -> ARMED. Fire events are dropped, not queued. Arm writes update the template; `arm_qty == 0` goes to IDLE and aborts the cooldown.
- A trigger already high on entry to ARMED does not fire; it must fall and rise again.
- Counter width is `$clog2(COOLDOWN_CYCLES+1)`, minimum 1.

## Timing
- Reset values: `order_valid` 0, `order_side` 0, `order_price` 0, `order_qty` 0, `order_id` 0, `armed` 0, `orders_sent` 0. Template and `trig_q` reset to 0.
- Reset asserted mid-SEND drops `order_valid` immediately (asynchronous); the order is lost and the state returns to IDLE.
- All outputs are registered.
- Fire sampled at edge k -> `order_valid` = 1 in the cycle after edge k (one-cycle latency).
- Price is sampled at edge k only; later book changes do not alter the offered order.
- Handshake at edge m:
  - `order_valid` = 0 after edge m.
  - With `COOLDOWN_CYCLES = C > 0`, `armed` = 1 after edge m+C.
  - A fire sampled at edge m+C+1 or later is accepted.
- `order_ready` may be high before `order_valid`; no combinational path from `order_ready` to `order_valid`.

## Configuration
- `ORDER_DISPATCHER_ONESHOT_EN` defined: after the handshake (and after COOLDOWN when `COOLDOWN_CYCLES > 0`), go to IDLE instead of ARMED. A new arm write is required before the next order.
- Not defined: automatic re-arm into ARMED as described above.

## Test plan
- Arm buy qty 10, `ask_price` = 0x64, pulse trigger, `order_ready` = 1 -> one order {side 0, price 0x64, qty 10, id 0}; valid for exactly one cycle; `orders_sent` = 1.
- Arm sell qty 5, `bid_price` = 0x50, fire, hold `order_ready` = 0 for 6 cycles while `bid_price` changes to 0x40 -> fields stay {1, 0x50, 5}; accepted on the 7th cycle.
- `COOLDOWN_CYCLES` = 4, trigger re-pulses 2 cycles after handshake -> no order. Re-pulse 6 cycles after handshake -> second order with id 1.
- Trigger held high through re-arm -> no order until it falls and rises again.
- Arm write with `arm_qty` = 0 during COOLDOWN -> IDLE, `armed` = 0; subsequent trigger produces no order.
- 256 accepted orders -> `order_id` wraps to 0, `orders_sent` stays at 255. Reset asserted during SEND -> all outputs 0 asynchronously.
